// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: per-cycle advance/hold/flush control for the 5-stage
// pipeline, with a data-memory wait timeout and saturating perf counters.
module hazard_ctrl_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_memRead,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs2,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_TOUT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WC_W-1:0]  wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic load_use;
  logic mem_stall;
  logic rs1_hit;
  logic rs2_hit;

  // {pc, if_id, id_ex, ex_mem}
  logic [3:0] wr;
  logic       fl_ifid;
  logic       fl_idex;
  logic       bub;
  logic       stall_inc;
  logic       flush_inc;

  logic [3:0] adv_wr;
  logic       adv_fi;
  logic       adv_fe;
  logic       adv_br;

  assign rs1_hit = (id_ex_rd == if_id_rs1);
  assign rs2_hit = if_id_uses_rs2 & (id_ex_rd == if_id_rs2);

  assign load_use = id_ex_memRead
                  & (id_ex_rd != 5'd0)
                  & (rs1_hit | rs2_hit);

  assign mem_stall = mem_req & ~mem_ready;

  // Branch wins over load-use: the dependent ID instruction is squashed anyway.
  always_comb begin
    adv_wr = 4'b1111;
    adv_fi = 1'b0;
    adv_fe = 1'b0;
    adv_br = 1'b0;
    if (ex_branch_taken) begin
      adv_fi = 1'b1;
      adv_fe = 1'b1;
      adv_br = 1'b1;
    end else if (load_use) begin
      adv_wr = 4'b0011;
      adv_fe = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    err_d     = err_q;
    wr        = 4'b1111;
    fl_ifid   = 1'b0;
    fl_idex   = 1'b0;
    bub       = 1'b0;
    flush_inc = 1'b0;

    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          wr      = 4'b0000;
          bub     = 1'b1;
          wait_d  = WC_W'(1);
          state_d = S_WAIT;
        end else begin
          wr        = adv_wr;
          fl_ifid   = adv_fi;
          fl_idex   = adv_fe;
          flush_inc = adv_br;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          wr        = adv_wr;
          fl_ifid   = adv_fi;
          fl_idex   = adv_fe;
          flush_inc = adv_br;
          wait_d    = '0;
          state_d   = S_RUN;
        end else begin
          wr  = 4'b0000;
          bub = 1'b1;
          if (wait_q == WC_LAST) begin
            state_d = S_TOUT;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + WC_W'(1);
          end
        end
      end
      S_TOUT: begin
        wr  = 4'b0000;
        bub = 1'b1;
      end
      default: begin
        state_d = S_RUN;
        wait_d  = '0;
      end
    endcase

    stall_inc = (state_q != S_TOUT) & ~wr[3];
  end

  // Reset forces a full freeze with bubbles regardless of state.
  assign pc_write      = rst_n & wr[3];
  assign if_id_write   = rst_n & wr[2];
  assign id_ex_write   = rst_n & wr[1];
  assign ex_mem_write  = rst_n & wr[0];
  assign if_id_flush   = ~rst_n | fl_ifid;
  assign id_ex_flush   = ~rst_n | fl_idex;
  assign mem_wb_bubble = ~rst_n | bub;

  assign mem_timeout_err = err_q;
  assign stall_cycles    = stall_q;
  assign flush_count     = flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (stall_inc && !(&stall_q)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush_inc && !(&flush_q)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

endmodule
